// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request/response/multiplier bus of mult_arbiter (slave = arbiter side, master = requester/multiplier side)
interface mult_arbiter_if #(
  parameter int W = 5,
  parameter int CNT_W = 8
);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic resp0_valid, resp0_ready, resp0_ovf, resp1_valid, resp1_ready, resp1_ovf;
  logic [W-1:0] resp0_out, resp1_out;
  logic [W-1:0] mult_a, mult_b, mult_out;
  logic mult_ovf, busy;
  logic [CNT_W-1:0] ops_done;
  modport slave (
    input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input resp0_ready, resp1_ready, mult_out, mult_ovf,
    output req0_ready, req1_ready, resp0_valid, resp0_out, resp0_ovf,
    output resp1_valid, resp1_out, resp1_ovf, mult_a, mult_b, busy, ops_done
  );
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output resp0_ready, resp1_ready, mult_out, mult_ovf,
    input req0_ready, req1_ready, resp0_valid, resp0_out, resp0_ovf,
    input resp1_valid, resp1_out, resp1_ovf, mult_a, mult_b, busy, ops_done
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multiplier between two valid/ready requesters (clk, async rst, bus: mult_arbiter_if.slave)
module mult_arbiter #(
  parameter int W = 5,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  mult_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state;
  logic owner, gptr, sel, go, done, ovf;
  logic [W-1:0] a, b, res;
  logic [CNT_W-1:0] ops;
  always_comb begin
    sel = (bus.req0_valid && bus.req1_valid) ? ~gptr : bus.req1_valid;
    go = !rst && state == IDLE && (bus.req0_valid || bus.req1_valid);
    done = state == HOLD && (owner ? bus.resp1_ready : bus.resp0_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      gptr <= 1'b1;
      a <= '0;
      b <= '0;
      res <= '0;
      ovf <= 1'b0;
      ops <= '0;
    end else if (go) begin
      a <= sel ? bus.req1_a : bus.req0_a;
      b <= sel ? bus.req1_b : bus.req0_b;
      owner <= sel;
      state <= CALC;
    end else if (state == CALC) begin
      res <= bus.mult_out;
      ovf <= bus.mult_ovf;
      state <= HOLD;
    end else if (done) begin
      gptr <= owner;
      ops <= ops + CNT_W'(1);
      state <= IDLE;
    end
  end
  assign bus.req0_ready = go && !sel;
  assign bus.req1_ready = go && sel;
  assign bus.resp0_valid = state == HOLD && !owner;
  assign bus.resp1_valid = state == HOLD && owner;
  assign bus.resp0_out = res;
  assign bus.resp1_out = res;
  assign bus.resp0_ovf = ovf;
  assign bus.resp1_ovf = ovf;
  assign bus.mult_a = a;
  assign bus.mult_b = b;
  assign bus.busy = state != IDLE;
  assign bus.ops_done = ops;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed self-checking bench for mult_arbiter with a behavioural 5-bit multiplier
module tb_mult_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [9:0] prod;
  mult_arbiter_if #(.W(5), .CNT_W(8)) bus ();
  mult_arbiter #(.W(5), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign prod = {5'd0, bus.mult_a} * {5'd0, bus.mult_b};
  assign bus.mult_out = prod[4:0];
  assign bus.mult_ovf = |prod[9:5];
  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.resp0_ready = 0; bus.resp1_ready = 0;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    clear_inputs();
    bus.req0_valid = 1;
    bus.req0_a = 3; bus.req0_b = 3;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {bus.busy, bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.mult_a, bus.mult_b, bus.resp0_out, bus.resp0_ovf, bus.ops_done} !== 24'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.mult_a, bus.mult_b, bus.resp0_out, bus.resp0_ovf, bus.ops_done});
    end
    rst = 0;
    clear_inputs();
  endtask
  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 5;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req0_valid = 0;
    checks++;
    if ({bus.busy, bus.resp0_valid, bus.mult_a, bus.mult_b} !== {1'b1, 1'b0, 5'd3, 5'd5}) begin
      failures++;
      $display("FAIL single_calc got=%b exp=%b", {bus.busy, bus.resp0_valid, bus.mult_a, bus.mult_b}, {1'b1, 1'b0, 5'd3, 5'd5});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp0_out, bus.resp0_ovf} !== {2'b10, 5'd15, 1'b0}) begin
      failures++;
      $display("FAIL single_resp got=%b exp=%b", {bus.resp0_valid, bus.resp1_valid, bus.resp0_out, bus.resp0_ovf}, {2'b10, 5'd15, 1'b0});
    end
    bus.resp0_ready = 1;
    @(negedge clk);
    bus.resp0_ready = 0;
    checks++;
    if ({bus.busy, bus.ops_done} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL single_done got=%b exp=%b", {bus.busy, bus.ops_done}, {1'b0, 8'd1});
    end
  endtask
  task automatic test_overflow();
    @(negedge clk);
    bus.req1_valid = 1; bus.req1_a = 7; bus.req1_b = 6;
    bus.resp0_ready = 1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid} !== 3'b010) begin
      failures++;
      $display("FAIL ovf_ready got=%b exp=010", {bus.req0_ready, bus.req1_ready, bus.resp0_valid});
    end
    @(negedge clk);
    bus.req1_valid = 0;
    checks++;
    if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_calc got=%b exp=00", {bus.resp0_valid, bus.resp1_valid});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp1_out, bus.resp1_ovf} !== {2'b01, 5'd10, 1'b1}) begin
      failures++;
      $display("FAIL ovf_resp got=%b exp=%b", {bus.resp0_valid, bus.resp1_valid, bus.resp1_out, bus.resp1_ovf}, {2'b01, 5'd10, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp1_valid, bus.ops_done} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL ovf_hold_wrong_ready got=%b exp=%b", {bus.resp1_valid, bus.ops_done}, {1'b1, 8'd1});
    end
    bus.resp1_ready = 1;
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.ops_done} !== {3'b000, 8'd2}) begin
      failures++;
      $display("FAIL ovf_done got=%b exp=%b", {bus.busy, bus.resp0_valid, bus.resp1_valid, bus.ops_done}, {3'b000, 8'd2});
    end
  endtask
  task automatic test_contention();
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      bit r = k[0];
      if (!r) begin
        bus.req0_valid = 1; bus.req0_a = 2; bus.req0_b = 2;
        bus.req1_valid = 1; bus.req1_a = 3; bus.req1_b = 3;
      end
      bus.resp0_ready = 0; bus.resp1_ready = 0;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== (r ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL contention_grant k=%0d got=%b exp=%b", k, {bus.req0_ready, bus.req1_ready}, r ? 2'b01 : 2'b10);
      end
      @(negedge clk);
      if (r) bus.req1_valid = 0; else bus.req0_valid = 0;
      @(negedge clk);
      checks++;
      if ({bus.resp0_valid, bus.resp1_valid, r ? bus.resp1_out : bus.resp0_out, bus.req0_ready, bus.req1_ready}
          !== {r ? 2'b01 : 2'b10, r ? 5'd9 : 5'd4, 2'b00}) begin
        failures++;
        $display("FAIL contention_resp k=%0d got=%b exp=%b", k, {bus.resp0_valid, bus.resp1_valid, r ? bus.resp1_out : bus.resp0_out, bus.req0_ready, bus.req1_ready}, {r ? 2'b01 : 2'b10, r ? 5'd9 : 5'd4, 2'b00});
      end
      if (r) bus.resp1_ready = 1; else bus.resp0_ready = 1;
      @(negedge clk);
    end
    clear_inputs();
    checks++;
    if (bus.ops_done !== 8'd4) begin
      failures++;
      $display("FAIL contention_count got=%0d exp=4", bus.ops_done);
    end
  endtask
  task automatic test_backpressure();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 6; bus.req0_b = 4;
    @(negedge clk);
    bus.req0_valid = 0;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 1;
    bus.req1_valid = 1; bus.req1_a = 2; bus.req1_b = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.resp0_valid, bus.resp0_out, bus.resp0_ovf, bus.req0_ready, bus.req1_ready, bus.busy} !== {1'b1, 5'd24, 1'b0, 2'b00, 1'b1}) begin
        failures++;
        $display("FAIL backpressure_hold i=%0d got=%b exp=%b", i, {bus.resp0_valid, bus.resp0_out, bus.resp0_ovf, bus.req0_ready, bus.req1_ready, bus.busy}, {1'b1, 5'd24, 1'b0, 2'b00, 1'b1});
      end
      @(negedge clk);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.resp0_ready = 1;
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({bus.busy, bus.ops_done} !== {1'b0, 8'd5}) begin
      failures++;
      $display("FAIL backpressure_done got=%b exp=%b", {bus.busy, bus.ops_done}, {1'b0, 8'd5});
    end
  endtask
  task automatic test_reset_midop();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 3;
    bus.resp0_ready = 1;
    @(negedge clk);
    bus.req0_valid = 0;
    rst = 1;
    #1;
    checks++;
    if ({bus.resp0_valid, bus.busy, bus.mult_a, bus.ops_done} !== 15'd0) begin
      failures++;
      $display("FAIL midop_reset got=%b exp=0", {bus.resp0_valid, bus.busy, bus.mult_a, bus.ops_done});
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.resp0_valid, bus.resp1_valid, bus.busy, bus.ops_done} !== 11'd0) begin
        failures++;
        $display("FAIL midop_dropped i=%0d got=%b exp=0", i, {bus.resp0_valid, bus.resp1_valid, bus.busy, bus.ops_done});
      end
    end
    clear_inputs();
  endtask
  task automatic test_back_to_back();
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    for (int i = 0; i < 256; i++) begin
      bit r = i[0];
      logic [4:0] a = 5'(i);
      logic [4:0] b = 5'(i * 7 + 3);
      int p = int'(a) * int'(b);
      @(negedge clk);
      if (r) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; end
      else begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; end
      #1;
      checks++;
      if ({r ? bus.req1_ready : bus.req0_ready, bus.ops_done} !== {1'b1, 8'(i)}) begin
        failures++;
        $display("FAIL b2b_issue i=%0d got=%b exp=%b", i, {r ? bus.req1_ready : bus.req0_ready, bus.ops_done}, {1'b1, 8'(i)});
      end
      @(negedge clk);
      bus.req0_valid = 0; bus.req1_valid = 0;
      @(negedge clk);
      checks++;
      if ({bus.resp0_valid, bus.resp1_valid, r ? bus.resp1_out : bus.resp0_out, r ? bus.resp1_ovf : bus.resp0_ovf}
          !== {r ? 2'b01 : 2'b10, 5'(p), p > 31}) begin
        failures++;
        $display("FAIL b2b_resp i=%0d got=%b exp=%b", i, {bus.resp0_valid, bus.resp1_valid, r ? bus.resp1_out : bus.resp0_out, r ? bus.resp1_ovf : bus.resp0_ovf}, {r ? 2'b01 : 2'b10, 5'(p), p > 31});
      end
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({bus.busy, bus.ops_done} !== 9'd0) begin
      failures++;
      $display("FAIL b2b_wrap got=%b exp=0", {bus.busy, bus.ops_done});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one combinational unsigned multiplier instance (W-bit operands, W-bit truncated product, overflow flag) between two independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers the operands onto the multiplier, captures the product and overflow flag, and holds the response until it is accepted. It sits between the switch/key input logic and the multiplier instance at the top level.

Parameters:
W, 5, operand and result width; must match the multiplier instance.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 pair accepted this cycle
req0_a  input  W  requester 0 operand a
req0_b  input  W  requester 0 operand b
req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 consumes result
resp0_out  output  W  product, low W bits
resp0_ovf  output  1  overflow flag from the multiplier
resp1_valid, resp1_ready, resp1_out, resp1_ovf  same as requester 0, for requester 1
mult_a  output  W  operand a to the multiplier
mult_b  output  W  operand b to the multiplier
mult_out  input  W  multiplier product
mult_ovf  input  1  multiplier overflow
busy  output  1  high whenever state is not IDLE
ops_done  output  CNT_W  count of completed (handshaken) responses

Behaviour:
- Reset values: state=IDLE, mult_a=0, mult_b=0, result and ovf registers=0, all req_ready and resp_valid=0, ops_done=0, grant pointer=1 (so requester 0 wins the first tie).
- FSM has three states: IDLE, CALC, HOLD.
- IDLE:
  - req_ready is combinational: high only for the selected requester, and only in IDLE.
  - Selection: if exactly one req_valid is high, that requester is selected.
  - If both are high, select the requester that is not the grant pointer.
  - On the cycle a request is accepted (valid and ready both high): latch a/b into mult_a/mult_b, record the owner, go to CALC.
  - With no request valid, stay in IDLE.
- CALC (one cycle): operands are stable on mult_a/mult_b. At the end of the cycle, capture mult_out and mult_ovf into the result registers, then go to HOLD.
- HOLD:
  - resp<owner>_valid=1 with resp_out and resp_ovf driven from the result registers. The other response valid stays 0.
  - Values stay stable until resp<owner>_ready=1.
  - On that handshake: grant pointer=owner, ops_done increments, go to IDLE.
- Latency: accept in cycle N gives resp_valid in cycle N+2.
- Minimum issue interval: 3 cycles (accept, CALC, HOLD with ready high).
- No request is accepted outside IDLE. A request that is not accepted must stay valid; the arbiter re-evaluates every IDLE cycle and keeps no stale grant.
- mult_a/mult_b keep the last operands after completion. They are not cleared.
- ops_done wraps from 2^CNT_W-1 to 0 without saturating.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset mid-operation (CALC or HOLD): the transaction is dropped with no response, and all state returns to its reset values immediately.
- Arithmetic: the block does no arithmetic on operands. out and ovf come from the multiplier unchanged.

Test Plan:
- Single request: after reset, req0 a=3, b=5 -> req0_ready high in the accept cycle; 2 cycles later resp0_valid=1, resp0_out=15, resp0_ovf=0; ops_done=1 after the handshake.
- Overflow: req1 a=7, b=6 -> resp1_out=10 (42 mod 32), resp1_ovf=1; resp0_valid stays 0 throughout.
- Contention:
  - Both valid from reset (req0 a=2,b=2; req1 a=3,b=3) -> req0 served first (out=4), then req1 (out=9).
  - Repeat with both valid -> order alternates, requester 0 first again.
- Backpressure: hold resp0_ready=0 for 4 cycles in HOLD -> resp0_valid, resp0_out and resp0_ovf stable; req0_ready and req1_ready stay 0; busy=1.
- Reset mid-op: assert rst during CALC -> next cycle resp0_valid=0, mult_a=0, ops_done=0, busy=0; no response is ever issued for the dropped request.
- Counter wrap: 256 back-to-back completed operations -> ops_done returns to 0. Every result matches the reference model (a*b mod 32; ovf=1 iff a*b>31).
